// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer scanout reader.
// Byte unpacking of the output stream is selected with FB_SCANOUT_BYTE_UNPACK_EN.
package fb_pkg;

   localparam int FB_ADDR_W         = 10;
   localparam int FB_DATA_W         = 32;
   localparam int FB_BYTES_PER_WORD = 4;

   // Read-master control states; IDLE encodes as zero so reset shows all-zero debug state.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fb_rd_state_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fb_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       pop_data_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   // A pop on an empty FIFO is ignored; a push into a full FIFO is only taken alongside a pop.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

   // Storage array; contents need no reset because the count gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over any push or pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop) begin
            count_q <= count_q + (PTR_W+1)'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - (PTR_W+1)'(1);
         end
      end
   end

   assign pop_data_o = mem_q[rd_ptr_q];
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;

endmodule

// File: rtl/fb_scanout_reader.sv
// Avalon-MM read master that streams a frame out of the frame-buffer memory
// as Avalon-ST beats with sop/eop markers.
// Define FB_SCANOUT_BYTE_UNPACK_EN to emit one byte per beat (byte 0 first).
//
// Stream handshake: a beat transfers on a cycle where st_valid and st_ready are
// both 1; while st_valid is 1 and st_ready is 0, st_data/st_sop/st_eop hold.
module fb_scanout_reader
   import fb_pkg::*;
#(
   parameter int ADDR_W      = FB_ADDR_W,
   parameter int DATA_W      = FB_DATA_W,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = 1024,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              continuous,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata,
`ifdef FB_SCANOUT_BYTE_UNPACK_EN
   output logic [7:0]        st_data,
`else
   output logic [DATA_W-1:0] st_data,
`endif
   output logic              st_valid,
   input  logic              st_ready,
   output logic              st_sop,
   output logic              st_eop,
   output logic              busy,
   output logic              frame_done,
   output fb_rd_state_t      state_dbg
);

`ifdef FB_SCANOUT_BYTE_UNPACK_EN
   localparam int BEATS_PER_WORD = FB_BYTES_PER_WORD;
`else
   localparam int BEATS_PER_WORD = 1;
`endif
   localparam int ISS_W  = ADDR_W + 1;
   localparam int BEAT_W = ADDR_W + 3;
   localparam logic [ISS_W-1:0]  ISS_LAST  = ISS_W'(FRAME_WORDS - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_WORDS * BEATS_PER_WORD - 1);
   localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

   fb_rd_state_t                    state_q;
   logic [ISS_W-1:0]                issue_cnt_q;
   logic [BEAT_W-1:0]               beat_cnt_q;
   logic                            pending_q;
   logic                            frame_done_q;

   logic [$clog2(FIFO_DEPTH):0]     fifo_count;
   logic                            fifo_empty;
   logic [DATA_W-1:0]               fifo_head;
   logic                            credit_ok;
   logic                            issue;
   logic                            accept;
   logic                            last_beat;
   logic                            word_pop;
   logic                            frame_end;
   logic                            abort_now;

   // A read is only issued when the FIFO is guaranteed room for its data, so capture never stalls.
   assign credit_ok = (int'(fifo_count) + int'(pending_q) + 1) <= FIFO_DEPTH;
   assign issue     = (state_q == FETCH) && credit_ok;
   assign accept    = st_valid && st_ready;
   assign last_beat = (beat_cnt_q == BEAT_LAST);
   assign frame_end = (state_q == DRAIN) && accept && last_beat;
   assign abort_now = abort && (state_q != IDLE);

`ifdef FB_SCANOUT_BYTE_UNPACK_EN
   assign word_pop = accept && (beat_cnt_q[1:0] == 2'd3);
`else
   assign word_pop = accept;
`endif

   fb_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (reset_n),
      .flush_i     (abort_now),
      .push_i      (pending_q),
      .push_data_i (mem_readdata),
      .pop_i       (word_pop),
      .pop_data_o  (fifo_head),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Control FSM plus issue/beat counters, capture flag and the frame_done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         issue_cnt_q  <= '0;
         beat_cnt_q   <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         pending_q    <= issue;
         if (issue) begin
            issue_cnt_q <= issue_cnt_q + ISS_W'(1);
         end
         if (accept) begin
            beat_cnt_q <= last_beat ? '0 : beat_cnt_q + BEAT_W'(1);
         end
         if (abort_now) begin
            // The read issued this cycle is dropped with the flushed FIFO contents.
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q     <= FETCH;
                     issue_cnt_q <= '0;
                  end
               end
               FETCH: begin
                  if (issue && (issue_cnt_q == ISS_LAST)) begin
                     state_q <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (frame_end) begin
                     frame_done_q <= 1'b1;
                     issue_cnt_q  <= '0;
                     state_q      <= continuous ? FETCH : IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Stream data is forced to zero when no beat is offered so idle outputs read as zero.
   always_comb begin
      st_data = '0;
      if (st_valid) begin
`ifdef FB_SCANOUT_BYTE_UNPACK_EN
         st_data = fifo_head[{beat_cnt_q[1:0], 3'b000} +: 8];
`else
         st_data = fifo_head;
`endif
      end
   end

   assign mem_chipselect = issue;
   assign mem_address    = issue ? (BASE + issue_cnt_q[ADDR_W-1:0]) : '0;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign mem_clken      = 1'b1;

   assign st_valid   = !fifo_empty;
   assign st_sop     = st_valid && (beat_cnt_q == '0);
   assign st_eop     = st_valid && last_beat;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

endmodule
